editor_campos_rtc: RTL

- Value editor driven by the 4-bit field address from the cursor/address counter.
- In edit mode (W_R=0), increments or decrements the addressed time/date/timer field, one step per button press.
- Holds all nine fields as packed BCD and issues a one-cycle write request so the RTC bus controller can push each edited value out.
- In read mode (W_R=1), takes field values loaded back from the RTC.

---
 rtl/editor_campos_rtc_if.sv | 36 +++
 rtl/editor_campos_rtc.sv | 114 +++++++++++
 2 files changed

// File: rtl/editor_campos_rtc_if.sv
// Bundle of controls, load path, field registers and write request for the RTC value editor.
// The master drives buttons and loads; the slave (editor) drives fields and write requests.
interface editor_campos_rtc_if #(
   parameter int unsigned DW = 8
);
   logic          en;
   logic          W_R;
   logic [3:0]    addr;
   logic          U;
   logic          B;
   logic          ld;
   logic [3:0]    ld_addr;
   logic [DW-1:0] ld_data;
   logic [DW-1:0] seg;
   logic [DW-1:0] min;
   logic [DW-1:0] hora;
   logic [DW-1:0] dia;
   logic [DW-1:0] mes;
   logic [DW-1:0] anio;
   logic [DW-1:0] t_seg;
   logic [DW-1:0] t_min;
   logic [DW-1:0] t_hora;
   logic          wr_req;
   logic [3:0]    wr_addr;
   logic [DW-1:0] wr_data;

   modport master (
      output en, W_R, addr, U, B, ld, ld_addr, ld_data,
      input  seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora, wr_req, wr_addr, wr_data
   );

   modport slave (
      input  en, W_R, addr, U, B, ld, ld_addr, ld_data,
      output seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora, wr_req, wr_addr, wr_data
   );
endinterface

// File: rtl/editor_campos_rtc.sv
// BCD field editor for RTC time/date/timer values: button-edge stepping with wrap,
// sanitised loads from the RTC read path, and a one-cycle write request per edit.
module editor_campos_rtc #(
   parameter int unsigned N_CAMPOS = 9,
   parameter int unsigned DW       = 8
) (
   input logic               clk,
   input logic               rst,
   editor_campos_rtc_if.slave bus
);

   logic [N_CAMPOS-1:0][DW-1:0] fields_q, fields_d;
   logic                        u_prev_q, b_prev_q;
   logic                        u_blk_q, u_blk_d, b_blk_q, b_blk_d;
   logic                        wr_req_q, wr_req_d;
   logic [3:0]                  wr_addr_q, wr_addr_d;
   logic [DW-1:0]               wr_data_q, wr_data_d;
   logic                        up_ev, dn_ev, edit, load;
   logic [DW-1:0]               cur, nxt;

   function automatic logic [DW-1:0] f_min(input logic [3:0] i);
      return (i == 4'd3 || i == 4'd4) ? DW'(8'h01) : DW'(8'h00);
   endfunction

   function automatic logic [DW-1:0] f_max(input logic [3:0] i);
      case (i)
         4'd0, 4'd1, 4'd6, 4'd7: return DW'(8'h59);
         4'd2, 4'd8:             return DW'(8'h23);
         4'd3:                   return DW'(8'h31);
         4'd4:                   return DW'(8'h12);
         4'd5:                   return DW'(8'h99);
         default:                return DW'(8'h00);
      endcase
   endfunction

   function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v, input logic [3:0] i);
      if (v == f_max(i))      return f_min(i);
      else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                     return v + DW'(1);
   endfunction

   function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v, input logic [3:0] i);
      if (v == f_min(i))      return f_max(i);
      else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      else                     return v - DW'(1);
   endfunction

   // Valid BCD digits are ordered like binary, so range checks compare directly.
   function automatic logic [DW-1:0] sanitize(input logic [DW-1:0] v, input logic [3:0] i);
      if (v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v >= f_min(i) && v <= f_max(i)) return v;
      else                                                                   return f_min(i);
   endfunction

   // Buttons already held when reset releases stay blocked until they are let go.
   assign up_ev = bus.U & ~u_prev_q & ~u_blk_q;
   assign dn_ev = bus.B & ~b_prev_q & ~b_blk_q;
   assign edit  = bus.en & ~bus.W_R & (bus.addr < 4'(N_CAMPOS)) & (up_ev ^ dn_ev);
   assign load  = bus.W_R & bus.ld & (bus.ld_addr < 4'(N_CAMPOS));
   assign u_blk_d = u_blk_q & bus.U;
   assign b_blk_d = b_blk_q & bus.B;

   always_comb begin
      fields_d  = fields_q;
      wr_req_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      cur       = fields_q[bus.addr];
      nxt       = up_ev ? bcd_inc(cur, bus.addr) : bcd_dec(cur, bus.addr);
      if (edit) begin
         fields_d[bus.addr] = nxt;
         wr_req_d           = 1'b1;
         wr_addr_d          = bus.addr;
         wr_data_d          = nxt;
      end else if (load) begin
         fields_d[bus.ld_addr] = sanitize(bus.ld_data, bus.ld_addr);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(N_CAMPOS); i++) fields_q[i] <= f_min(4'(i));
         u_prev_q  <= 1'b0;
         b_prev_q  <= 1'b0;
         u_blk_q   <= 1'b1;
         b_blk_q   <= 1'b1;
         wr_req_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         fields_q  <= fields_d;
         u_prev_q  <= bus.U;
         b_prev_q  <= bus.B;
         u_blk_q   <= u_blk_d;
         b_blk_q   <= b_blk_d;
         wr_req_q  <= wr_req_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign bus.seg     = fields_q[0];
   assign bus.min     = fields_q[1];
   assign bus.hora    = fields_q[2];
   assign bus.dia     = fields_q[3];
   assign bus.mes     = fields_q[4];
   assign bus.anio    = fields_q[5];
   assign bus.t_seg   = fields_q[6];
   assign bus.t_min   = fields_q[7];
   assign bus.t_hora  = fields_q[8];
   assign bus.wr_req  = wr_req_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

endmodule
